// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode enum, flag bit positions and the
// multiply sequencing states.
package alu_pkg;

    // Opcodes 10..15 are illegal and fall outside this enum on purpose.
    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpAnd = 4'd2,
        OpOr  = 4'd3,
        OpXor = 4'd4,
        OpSll = 4'd5,
        OpSrl = 4'd6,
        OpSra = 4'd7,
        OpSlt = 4'd8,
        OpMul = 4'd9
    } op_e;

    // Bit positions inside the 4-bit {N, Z, C, V} flag vector.
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b and clear the accumulator (step count 0)
//   a, b       : multiplicand / multiplier, sampled only on start
//   busy       : steps still outstanding
//   done       : the step taken at the coming edge is the last one
//   product    : 2*WIDTH product including the step in progress, so it is
//                final in the cycle where done is high and stays held after
module alu_mul_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;
    logic               busy_q, busy_d;
    logic               last_step;

    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = (count_q == CW'(WIDTH - 1));

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        busy_d   = busy_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            count_d  = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            // WIDTH is a power of two, so the count wraps back to 0 here.
            count_d  = count_q + 1'b1;
            if (last_step) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && last_step;
    assign product = busy_q ? acc_step : acc_q;

endmodule

// File: rtl/pipelined_alu.sv
// Registered ALU with valid/ready on both sides and {N, Z, C, V} flags.
// Single-cycle ops write the output register at the accept edge; MUL runs
// through alu_mul_seq for WIDTH edges and blocks new input meanwhile.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready is combinational)
//   a, b, op             : operands and opcode (op_e encoding)
//   out_valid / out_ready: result handshake
//   result, flags        : registered result and {N, Z, C, V}
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int unsigned SHW = $clog2(WIDTH);

    // ---------------- combinational single-cycle datapath ----------------
    logic [WIDTH:0]     add_full, sub_full;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    logic [3:0]         alu_flags;

    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt    = b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OpAdd: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OpSub: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OpAnd:   alu_res = a & b;
            OpOr:    alu_res = a | b;
            OpXor:   alu_res = a ^ b;
            OpSll:   alu_res = a << shamt;
            OpSrl:   alu_res = a >> shamt;
            OpSra:   alu_res = $signed(a) >>> shamt;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            default: alu_res = '0;  // MUL goes through the sequencer; 10..15 illegal
        endcase
    end

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;
    end

    // ---------------- multiplier ----------------
    logic               mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   mul_res;
    logic               mul_hi;
    logic [3:0]         mul_flags;

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign mul_res = mul_product[WIDTH-1:0];
    assign mul_hi  = |mul_product[2*WIDTH-1:WIDTH];

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_N] = mul_res[WIDTH-1];
        mul_flags[FLAG_Z] = (mul_res == '0);
        mul_flags[FLAG_C] = mul_hi;
        mul_flags[FLAG_V] = mul_hi;
    end

    // ---------------- FSM and output register ----------------
    mul_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             out_free, accept, wr;

    assign out_free = !out_valid_q || out_ready;
    // mul_busy is always low in StIdle; it keeps the sequencer's view explicit.
    assign in_ready = rst_n && (state_q == StIdle) && !mul_busy && out_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        wr        = 1'b0;
        result_d  = result_q;
        flags_d   = flags_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op == OpMul) begin
                        mul_start = 1'b1;
                        state_d   = StMul;
                    end else begin
                        wr       = 1'b1;
                        result_d = alu_res;
                        flags_d  = alu_flags;
                    end
                end
            end
            StMul: begin
                if (mul_done) begin
                    if (out_free) begin
                        wr       = 1'b1;
                        result_d = mul_res;
                        flags_d  = mul_flags;
                        state_d  = StIdle;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // Sequencer holds the finished product until the register frees up.
                if (out_free) begin
                    wr       = 1'b1;
                    result_d = mul_res;
                    flags_d  = mul_flags;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        out_valid_d = out_valid_q;
        if (wr) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule
